// File: rtl/byte_serializer_pkg.sv
// Shared constants for the serializer slice: serializer FSM states, default word
// width, and the state encoding of the downstream "101" sequence detector.
package byte_serializer_pkg;

  localparam int SER_DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  typedef enum logic [1:0] {
    DET_S0  = 2'd0,
    DET_S1  = 2'd1,
    DET_S10 = 2'd2
  } det_state_t;

endpackage

// File: rtl/byte_serializer_detector.sv
// Overlapping "101" detector fed by the serializer's sout. dout is Mealy so it
// pulses in the same cycle the final 1 of the pattern is on din.
module byte_serializer_detector
  import byte_serializer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  det_state_t state;

  assign dout = (state == DET_S10) && din;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DET_S0;
    end else begin
      case (state)
        DET_S0:  state <= din ? DET_S1 : DET_S0;
        DET_S1:  state <= din ? DET_S1 : DET_S10;
        DET_S10: state <= din ? DET_S1 : DET_S0;
        default: state <= DET_S0;
      endcase
    end
  end

endmodule

// File: rtl/byte_serializer_system.sv
// System wrapper: the serializer's bit stream drives the sequence detector.
module byte_serializer_system
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             dout
);

  byte_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  byte_serializer_detector u_det (
    .clk  (clk),
    .rst  (rst),
    .din  (sout),
    .dout (dout)
  );

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with a one-word hold register so back-to-back
// words stream out with no gap cycles. All serial outputs are registered.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] load_word;
  logic             load_bit;
  logic [WIDTH-1:0] load_rest;
  logic             reg_bit;
  logic [WIDTH-1:0] reg_rest;

  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign last_bit = (count == LAST);
  assign busy     = (state == SHIFT) || hold_full;

  // The first bit of a word goes straight to sout; the shifter keeps the rest.
  assign load_word = hold_full ? hold : in_data;
  assign load_bit  = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
  assign load_rest = MSB_FIRST ? {load_word[WIDTH-2:0], 1'b0} : {1'b0, load_word[WIDTH-1:1]};
  assign reg_bit   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign reg_rest  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      sreg        <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      sout        <= IDLE_BIT;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          sout       <= IDLE_BIT;
          sout_valid <= 1'b0;
          if (accept) begin
            state       <= SHIFT;
            count       <= '0;
            sreg        <= load_rest;
            sout        <= load_bit;
            sout_valid  <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            count <= count + CW'(1);
            sreg  <= reg_rest;
            sout  <= reg_bit;
            if (accept) begin
              hold      <= in_data;
              hold_full <= 1'b1;
            end
          end else if (hold_full || accept) begin
            // A held word always predates any new offer, and in_ready is low
            // while hold is full, so the two sources never collide.
            count       <= '0;
            sreg        <= load_rest;
            sout        <= load_bit;
            frame_start <= 1'b1;
            hold_full   <= 1'b0;
          end else begin
            state      <= IDLE;
            count      <= '0;
            sout       <= IDLE_BIT;
            sout_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: MSB-first and LSB-first instances plus the
// serializer+detector wrapper, all sharing clk and rst.
module tb_byte_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, sout, sout_valid, frame_start, busy;

  logic [7:0] lsb_data = 8'h00;
  logic       lsb_valid = 1'b0;
  logic       lsb_ready, lsb_sout, lsb_sout_valid, lsb_frame_start, lsb_busy;

  logic [7:0] sys_data = 8'h00;
  logic       sys_valid = 1'b0;
  logic       sys_ready, sys_sout, sys_sout_valid, sys_frame_start, sys_busy, sys_dout;

  int n_cmp = 0;
  int n_fail = 0;

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start), .busy(busy)
  );

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(lsb_data), .in_valid(lsb_valid), .in_ready(lsb_ready),
    .sout(lsb_sout), .sout_valid(lsb_sout_valid), .frame_start(lsb_frame_start), .busy(lsb_busy)
  );

  byte_serializer_system #(.WIDTH(8)) sys (
    .clk(clk), .rst(rst), .in_data(sys_data), .in_valid(sys_valid), .in_ready(sys_ready),
    .sout(sys_sout), .sout_valid(sys_sout_valid), .frame_start(sys_frame_start),
    .busy(sys_busy), .dout(sys_dout)
  );

  task automatic test_reset();
    rst = 1'b1;
    in_data = 8'hC3;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (sout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sout: got %b expected 0", sout); end
    n_cmp++; if (sout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sout_valid: got %b expected 0", sout_valid); end
    n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_accept_busy: got %b expected 0", busy); end
    n_cmp++; if (sout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_accept_valid: got %b expected 0", sout_valid); end
  endtask

  task automatic test_single();
    logic [7:0] word;
    logic exp_bit, exp_valid, exp_fs;
    word = 8'hA5;
    in_data = word;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      exp_bit = 1'b0;
      if (c <= 8) exp_bit = word[8-c];
      exp_valid = (c <= 8);
      exp_fs = (c == 1);
      n_cmp++; if (sout !== exp_bit) begin n_fail++; $display("[TB] FAIL single_sout cycle %0d: got %b expected %b", c, sout, exp_bit); end
      n_cmp++; if (sout_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL single_valid cycle %0d: got %b expected %b", c, sout_valid, exp_valid); end
      n_cmp++; if (frame_start !== exp_fs) begin n_fail++; $display("[TB] FAIL single_frame_start cycle %0d: got %b expected %b", c, frame_start, exp_fs); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic exp_bit, exp_valid, exp_fs, exp_ready;
    stream = 16'hA53C;
    in_data = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h3C;
    for (int c = 1; c <= 17; c++) begin
      exp_bit = 1'b0;
      if (c <= 16) exp_bit = stream[16-c];
      exp_valid = (c <= 16);
      exp_fs = (c == 1) || (c == 9);
      exp_ready = (c == 1) || (c >= 9);
      n_cmp++; if (sout !== exp_bit) begin n_fail++; $display("[TB] FAIL b2b_sout cycle %0d: got %b expected %b", c, sout, exp_bit); end
      n_cmp++; if (sout_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL b2b_valid cycle %0d: got %b expected %b", c, sout_valid, exp_valid); end
      n_cmp++; if (frame_start !== exp_fs) begin n_fail++; $display("[TB] FAIL b2b_frame_start cycle %0d: got %b expected %b", c, frame_start, exp_fs); end
      n_cmp++; if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL b2b_in_ready cycle %0d: got %b expected %b", c, in_ready, exp_ready); end
      if (c == 2) in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_three_words();
    logic [23:0] stream;
    logic exp_bit, exp_valid, exp_fs, exp_ready;
    stream = 24'hA53C5A;
    in_data = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h3C;
    for (int c = 1; c <= 25; c++) begin
      exp_bit = 1'b0;
      if (c <= 24) exp_bit = stream[24-c];
      exp_valid = (c <= 24);
      exp_fs = (c == 1) || (c == 9) || (c == 17);
      exp_ready = (c == 1) || (c == 9) || (c >= 17);
      n_cmp++; if (sout !== exp_bit) begin n_fail++; $display("[TB] FAIL three_sout cycle %0d: got %b expected %b", c, sout, exp_bit); end
      n_cmp++; if (sout_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL three_valid cycle %0d: got %b expected %b", c, sout_valid, exp_valid); end
      n_cmp++; if (frame_start !== exp_fs) begin n_fail++; $display("[TB] FAIL three_frame_start cycle %0d: got %b expected %b", c, frame_start, exp_fs); end
      n_cmp++; if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL three_in_ready cycle %0d: got %b expected %b", c, in_ready, exp_ready); end
      if (c == 2) in_data = 8'h5A;
      if (c == 10) in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_word();
    int leaked;
    in_data = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ready_before: got %b expected 0", in_ready); end
    n_cmp++; if (sout !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_sout_before: got %b expected 1", sout); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (sout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid: got %b expected 0", sout_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (sout !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_sout: got %b expected 0", sout); end
    leaked = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sout_valid !== 1'b0 || frame_start !== 1'b0) leaked++;
    end
    n_cmp++; if (leaked !== 0) begin n_fail++; $display("[TB] FAIL midrst_leaked_bits: got %0d expected 0", leaked); end
    in_data = 8'h80;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (sout !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_first_sout: got %b expected 1", sout); end
    n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_first_fs: got %b expected 1", frame_start); end
    n_cmp++; if (sout_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_first_valid: got %b expected 1", sout_valid); end
    repeat (9) @(negedge clk);
  endtask

  task automatic test_lsb_first();
    logic [7:0] word;
    logic exp_bit, exp_valid;
    word = 8'h01;
    lsb_data = word;
    lsb_valid = 1'b1;
    @(negedge clk);
    lsb_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      exp_bit = 1'b0;
      if (c <= 8) exp_bit = word[c-1];
      exp_valid = (c <= 8);
      n_cmp++; if (lsb_sout !== exp_bit) begin n_fail++; $display("[TB] FAIL lsb_sout cycle %0d: got %b expected %b", c, lsb_sout, exp_bit); end
      n_cmp++; if (lsb_sout_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL lsb_valid cycle %0d: got %b expected %b", c, lsb_sout_valid, exp_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_system();
    int pulses;
    logic exp_dout;
    pulses = 0;
    sys_data = 8'h05;
    sys_valid = 1'b1;
    @(negedge clk);
    sys_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp_dout = (c == 8);
      n_cmp++; if (sys_dout !== exp_dout) begin n_fail++; $display("[TB] FAIL sys_dout cycle %0d: got %b expected %b", c, sys_dout, exp_dout); end
      if (sys_dout === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("[TB] FAIL sys_pulse_count: got %0d expected 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_three_words();
    test_reset_mid_word();
    test_lsb_first();
    test_system();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning word width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = bit WIDTH-1 goes out first and 0 = bit 0 goes out first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0, meaning the level driven on sout when no bit is valid.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 sout  output  1  serial bit stream; feeds the downstream sequence detector's din.
REQ-010 sout_valid  output  1  sout carries a data bit this cycle.
REQ-011 frame_start  output  1  single-cycle pulse coincident with the first bit of each word.
REQ-012 busy  output  1  shifter active or hold register full.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid && in_ready; in_valid may rise independently of in_ready.
REQ-014 The block SHALL contain a one-word hold register, and in_ready SHALL be !hold_full, registered-state based and with no combinational path from in_valid.
REQ-015 The FSM SHALL have states IDLE and SHIFT, plus a bit counter of width clog2(WIDTH) counting 0..WIDTH-1.
REQ-016 In IDLE, an accepted word SHALL load the shift register directly, the FSM SHALL go to SHIFT, and the first bit SHALL appear on sout with sout_valid=1 and frame_start=1 in the cycle after the accept edge (latency 1).
REQ-017 In SHIFT, one bit SHALL be presented per cycle: bit count 0..WIDTH-1, order per MSB_FIRST; sout_valid=1 throughout.
REQ-018 In SHIFT before the last bit, an accepted word SHALL go to the hold register (hold_full=1).
REQ-019 On the last-bit edge (count=WIDTH-1) with hold full, the hold word SHALL move to the shift register, hold_full SHALL clear, the count SHALL reset to 0, and the FSM SHALL stay in SHIFT; the next word SHALL follow with zero gap cycles.
REQ-020 On the last-bit edge with hold empty and a simultaneous accept, the accepted word SHALL load the shift register directly with zero gap cycles.
REQ-021 On the last-bit edge with hold empty and no accept, the FSM SHALL go to IDLE.
REQ-022 In IDLE, sout SHALL be IDLE_BIT, sout_valid=0 and frame_start=0.
REQ-023 Sustained throughput SHALL be one word per WIDTH cycles; bits SHALL never be dropped, duplicated or reordered.
REQ-024 sout, sout_valid and frame_start SHALL be driven from registers (no combinational path from inputs).
REQ-025 busy SHALL equal (state==SHIFT) || hold_full.

Reset
REQ-026 While rst=1 on an edge, the block SHALL set state=IDLE, count=0, hold_full=0, shift register=0, sout=IDLE_BIT, sout_valid=0, frame_start=0 and in_ready=1, and SHALL accept no word on that edge.
REQ-027 rst asserted mid-word SHALL discard the partial word and the held word, with no further bits emitted; the first accept after reset SHALL behave per REQ-016.

Structure
REQ-028 The state encoding localparams (IDLE, SHIFT) and the default WIDTH SHALL live in a shared package alongside the sequence-detector state constants.
REQ-029 The block SHALL be a single module with no sub-modules; the hold register and the shifter SHALL be inline.
REQ-030 A top-level wrapper SHALL connect sout to the detector's din and rst/clk to both blocks; sout_valid is not used by the detector.

Verification
REQ-031 The bench SHALL cover: rst, then single word 0xA5 accepted at edge 0 with MSB_FIRST=1 -> sout 1,0,1,0,0,1,0,1 on cycles 1..8 with sout_valid=1, frame_start only on cycle 1, sout=0 and sout_valid=0 on cycle 9.
REQ-032 The bench SHALL cover: back-to-back 0xA5 then 0x3C, in_valid held high -> 16 contiguous valid bits with no gap, in_ready=0 from the cycle after the second accept until the hold-to-shift transfer, and frame_start on cycles 1 and 9.
REQ-033 The bench SHALL cover: three words offered with in_valid held high -> the third word is stalled (in_ready=0) until the last-bit edge of the first word, and all 24 bits emerge in order.
REQ-034 The bench SHALL cover: rst pulsed on cycle 4 of word 0xFF with hold holding 0x00 -> sout_valid=0 from the next cycle, in_ready=1, busy=0, and neither word is emitted afterwards.
REQ-035 The bench SHALL cover: MSB_FIRST=0 with word 0x01 -> sout 1,0,0,0,0,0,0,0.
REQ-036 The bench SHALL cover: system-level word 0x05 through the wrapper -> the detector dout pulses once, on the cycle the final bit 1 is presented.
